ex_mem_stage: RTL and testbench

// Execute stage plus EX/MEM pipeline register. Consumes the ID/EX buffer outputs
// (control bits, DR1/DR2, write address), computes the ALU result, and registers

---
 rtl/ex_mem_stage_if.sv | 41 ++++
 rtl/ex_mem_stage.sv | 96 +++++++++
 tb/tb_ex_mem_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// Execute-stage bus: ID/EX operands and controls in, EX/MEM register contents out.
// The master drives the ID/EX side; the slave is the stage that owns the EX/MEM register.
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int OP_W   = 4
);
  logic              dataIn_valid;
  logic              dataIn_wE_BR;
  logic [OP_W-1:0]   dataIn_OP_alu;
  logic              dataIn_SEL_dmx;
  logic              dataIn_W_ram;
  logic              dataIn_R_ram;
  logic [DATA_W-1:0] dataIn_DR1;
  logic [DATA_W-1:0] dataIn_DR2;
  logic [RA_W-1:0]   waIn_BR;

  logic              dataOut_valid;
  logic              dataOut_wE_BR;
  logic              dataOut_SEL_dmx;
  logic              dataOut_W_ram;
  logic              dataOut_R_ram;
  logic [DATA_W-1:0] dataOut_ALU;
  logic [DATA_W-1:0] dataOut_ST;
  logic [RA_W-1:0]   waOut_BR;
  logic              zeroOut;

  modport master (
    output dataIn_valid, dataIn_wE_BR, dataIn_OP_alu, dataIn_SEL_dmx, dataIn_W_ram,
           dataIn_R_ram, dataIn_DR1, dataIn_DR2, waIn_BR,
    input  dataOut_valid, dataOut_wE_BR, dataOut_SEL_dmx, dataOut_W_ram, dataOut_R_ram,
           dataOut_ALU, dataOut_ST, waOut_BR, zeroOut
  );

  modport slave (
    input  dataIn_valid, dataIn_wE_BR, dataIn_OP_alu, dataIn_SEL_dmx, dataIn_W_ram,
           dataIn_R_ram, dataIn_DR1, dataIn_DR2, waIn_BR,
    output dataOut_valid, dataOut_wE_BR, dataOut_SEL_dmx, dataOut_W_ram, dataOut_R_ram,
           dataOut_ALU, dataOut_ST, waOut_BR, zeroOut
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ALU plus EX/MEM register, 1-cycle latency; no backpressure of its own, the
// hazard unit holds it with stall or empties it with flush (flush wins).
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int OP_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  ex_mem_stage_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [OP_W-1:0] OP_AND = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] OP_NOR = OP_W'(4'b1100);
  localparam logic [OP_W-1:0] OP_SLL = OP_W'(4'b1000);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(4'b1001);
  localparam logic [OP_W-1:0] OP_SRA = OP_W'(4'b1010);

  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] aluRes;

  logic              validQ;
  logic              wEQ;
  logic              selQ;
  logic              wrQ;
  logic              rdQ;
  logic [DATA_W-1:0] aluQ;
  logic [DATA_W-1:0] stQ;
  logic [RA_W-1:0]   waQ;
  logic              zeroQ;

  assign opA   = bus.dataIn_DR1;
  assign opB   = bus.dataIn_DR2;
  assign shamt = opB[SH_W-1:0];

  always_comb begin
    aluRes = '0;
    case (bus.dataIn_OP_alu)
      OP_AND:  aluRes = opA & opB;
      OP_OR:   aluRes = opA | opB;
      OP_ADD:  aluRes = opA + opB;
      OP_SUB:  aluRes = opA - opB;
      OP_SLT:  aluRes = {{(DATA_W-1){1'b0}}, ($signed(opA) < $signed(opB))};
      OP_NOR:  aluRes = ~(opA | opB);
      OP_SLL:  aluRes = opA << shamt;
      OP_SRL:  aluRes = opA >> shamt;
      OP_SRA:  aluRes = $signed(opA) >>> shamt;
      default: aluRes = '0;
    endcase
  end

  // A slot without a valid instruction still carries its data, but must not
  // trigger any register-file or RAM side effect downstream.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      validQ <= 1'b0;
      wEQ    <= 1'b0;
      selQ   <= 1'b0;
      wrQ    <= 1'b0;
      rdQ    <= 1'b0;
      aluQ   <= '0;
      stQ    <= '0;
      waQ    <= '0;
      zeroQ  <= 1'b0;
    end else if (!stall) begin
      validQ <= bus.dataIn_valid;
      wEQ    <= bus.dataIn_valid & bus.dataIn_wE_BR;
      selQ   <= bus.dataIn_valid & bus.dataIn_SEL_dmx;
      wrQ    <= bus.dataIn_valid & bus.dataIn_W_ram;
      rdQ    <= bus.dataIn_valid & bus.dataIn_R_ram;
      aluQ   <= aluRes;
      stQ    <= opB;
      waQ    <= bus.waIn_BR;
      zeroQ  <= (aluRes == '0);
    end
  end

  assign bus.dataOut_valid   = validQ;
  assign bus.dataOut_wE_BR   = wEQ;
  assign bus.dataOut_SEL_dmx = selQ;
  assign bus.dataOut_W_ram   = wrQ;
  assign bus.dataOut_R_ram   = rdQ;
  assign bus.dataOut_ALU     = aluQ;
  assign bus.dataOut_ST      = stQ;
  assign bus.waOut_BR        = waQ;
  assign bus.zeroOut         = zeroQ;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed vector table followed by random traffic against an arithmetic reference model.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic stall;
  logic flush;

  ex_mem_stage_if #(.DATA_W(32), .RA_W(5), .OP_W(4)) bus ();

  ex_mem_stage #(.DATA_W(32), .RA_W(5), .OP_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct packed {
    logic        v;
    logic        we;
    logic        sel;
    logic        wr;
    logic        rd;
    logic [31:0] alu;
    logic [31:0] st;
    logic [4:0]  wa;
    logic        zero;
  } out_t;

  typedef struct {
    logic        r, s, f, v, we, sel, wr, rd;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  wa;
    out_t        e;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];
  out_t mdl;

  function automatic out_t mko(input logic v, we, sel, wr, rd, input logic [31:0] alu, st,
                               input logic [4:0] wa, input logic zero);
    out_t o;
    o.v = v; o.we = we; o.sel = sel; o.wr = wr; o.rd = rd;
    o.alu = alu; o.st = st; o.wa = wa; o.zero = zero;
    return o;
  endfunction

  function automatic vec_t mkv(input logic r, s, f, v, we, sel, wr, rd, input logic [3:0] op,
                               input logic [31:0] a, b, input logic [4:0] wa, input out_t e);
    vec_t x;
    x.r = r; x.s = s; x.f = f; x.v = v; x.we = we; x.sel = sel; x.wr = wr; x.rd = rd;
    x.op = op; x.a = a; x.b = b; x.wa = wa; x.e = e;
    return x;
  endfunction

  // Reference ALU: subtraction, compares and shifts rebuilt from plain arithmetic.
  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, b);
    logic [63:0] wide;
    logic [31:0] pw;
    pw = 32'd1 << b[4:0];
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a + ~b + 32'd1;
      4'b0111: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'b1100: return ~a & ~b;
      4'b1000: begin wide = {32'd0, a} * {32'd0, pw}; return wide[31:0]; end
      4'b1001: return a / pw;
      4'b1010: return a[31] ? ~((~a) / pw) : a / pw;
      default: return 32'd0;
    endcase
  endfunction

  function automatic out_t refNext(input out_t cur, input vec_t x);
    out_t n;
    logic [31:0] res;
    if (x.r || x.f) return '0;
    if (x.s) return cur;
    res = refAlu(x.op, x.a, x.b);
    n.v = x.v; n.we = x.v && x.we; n.sel = x.v && x.sel;
    n.wr = x.v && x.wr; n.rd = x.v && x.rd;
    n.alu = res; n.st = x.b; n.wa = x.wa; n.zero = (res == 32'd0);
    return n;
  endfunction

  task automatic apply(input vec_t x);
    rst = x.r; stall = x.s; flush = x.f;
    bus.dataIn_valid   = x.v;
    bus.dataIn_wE_BR   = x.we;
    bus.dataIn_SEL_dmx = x.sel;
    bus.dataIn_W_ram   = x.wr;
    bus.dataIn_R_ram   = x.rd;
    bus.dataIn_OP_alu  = x.op;
    bus.dataIn_DR1     = x.a;
    bus.dataIn_DR2     = x.b;
    bus.waIn_BR        = x.wa;
  endtask

  function automatic out_t actual();
    out_t o;
    o.v = bus.dataOut_valid; o.we = bus.dataOut_wE_BR; o.sel = bus.dataOut_SEL_dmx;
    o.wr = bus.dataOut_W_ram; o.rd = bus.dataOut_R_ram; o.alu = bus.dataOut_ALU;
    o.st = bus.dataOut_ST; o.wa = bus.waOut_BR; o.zero = bus.zeroOut;
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%b we=%b sel=%b wr=%b rd=%b alu=%h st=%h wa=%0d z=%b, expected v=%b we=%b sel=%b wr=%b rd=%b alu=%h st=%h wa=%0d z=%b",
               name, act.v, act.we, act.sel, act.wr, act.rd, act.alu, act.st, act.wa, act.zero,
               exp.v, exp.we, exp.sel, exp.wr, exp.rd, exp.alu, exp.st, exp.wa, exp.zero);
    end
  endtask

  initial begin
    //                 r  s  f  v we sel wr rd  op       a             b             wa  expected
    tbl.push_back(mkv(1, 0, 0, 1, 1, 1, 1, 1, 4'b0010, 32'd7,        32'd5,        3,  mko(0,0,0,0,0, 32'd0, 32'd0, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 4'b0010, 32'd7,        32'd5,        3,  mko(1,1,0,0,0, 32'd12, 32'd5, 3, 0)));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 4'b0110, 32'h1234,     32'h1234,     7,  mko(1,1,0,0,0, 32'd0, 32'h1234, 7, 1)));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 4'b0111, 32'hFFFF_FFFF, 32'd1,       1,  mko(1,1,0,0,0, 32'd1, 32'd1, 1, 0)));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 1, 0, 1, 4'b1010, 32'h8000_0000, 32'd4,       5,  mko(1,1,1,0,1, 32'hF800_0000, 32'd4, 5, 0)));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 1, 0, 4'b1001, 32'h8000_0000, 32'd4,       6,  mko(1,0,0,1,0, 32'h0800_0000, 32'd4, 6, 0)));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 1, 1, 1, 4'b0000, 32'hF0,       32'h3C,       9,  mko(0,0,0,0,0, 32'h30, 32'h3C, 9, 0)));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 1, 1, 1, 4'b0001, 32'h100,      32'h1,        2,  mko(1,0,1,1,1, 32'h101, 32'h1, 2, 0)));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 4'b1100, 32'd0,        32'd0,        8,  mko(1,1,0,0,0, 32'hFFFF_FFFF, 32'd0, 8, 0)));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 4'b1111, 32'd5,        32'd6,        10, mko(1,1,0,0,0, 32'd0, 32'd6, 10, 1)));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 4'b1000, 32'd3,        32'd35,       11, mko(1,1,0,0,0, 32'd24, 32'd35, 11, 0)));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 4'b0010, 32'hFFFF_FFFF, 32'd1,       12, mko(1,1,0,0,0, 32'd0, 32'd1, 12, 1)));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 4'b0010, 32'd2,        32'd3,        4,  mko(1,1,0,0,0, 32'd5, 32'd3, 4, 0)));
    tbl.push_back(mkv(0, 1, 0, 1, 1, 0, 0, 0, 4'b0010, 32'd9,        32'd9,        6,  mko(1,1,0,0,0, 32'd5, 32'd3, 4, 0)));
    tbl.push_back(mkv(0, 1, 0, 1, 1, 0, 0, 0, 4'b0010, 32'd9,        32'd9,        6,  mko(1,1,0,0,0, 32'd5, 32'd3, 4, 0)));
    tbl.push_back(mkv(0, 1, 1, 1, 1, 0, 1, 0, 4'b0010, 32'd9,        32'd9,        6,  mko(0,0,0,0,0, 32'd0, 32'd0, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 4'b0010, 32'd1,        32'd1,        13, mko(1,1,0,0,0, 32'd2, 32'd1, 13, 0)));
    tbl.push_back(mkv(1, 1, 0, 1, 1, 1, 1, 1, 4'b0001, 32'hAA,       32'h55,       14, mko(0,0,0,0,0, 32'd0, 32'd0, 0, 0)));

    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i), actual(), tbl[i].e);
    end

    // The table ends on a reset row, so the model starts from an empty register.
    mdl = '0;
    for (int n = 0; n < 400; n++) begin
      vec_t x;
      x.r   = ($urandom_range(0, 31) == 0);
      x.s   = ($urandom_range(0, 3) == 0);
      x.f   = ($urandom_range(0, 7) == 0);
      x.v   = ($urandom_range(0, 4) != 0);
      x.we  = 1'($urandom);
      x.sel = 1'($urandom);
      x.wr  = 1'($urandom);
      x.rd  = 1'($urandom);
      x.op  = 4'($urandom);
      x.a   = $urandom;
      case ($urandom_range(0, 2))
        0:       x.b = $urandom;
        1:       x.b = 32'($urandom_range(0, 40));
        default: x.b = x.a;
      endcase
      x.wa  = 5'($urandom);
      x.e   = '0;
      mdl = refNext(mdl, x);
      apply(x);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d op=%b", n, x.op), actual(), mdl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
